// File: rtl/wb_write_queue_if.sv
// Bundles the write-queue producer, register-file write port, status and bypass signals.
// slave = the queue itself; master = whatever drives producers and observes the write port.
interface wb_write_queue_if #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              alu_valid;
    logic              alu_ready;
    logic [ADDR_W-1:0] alu_reg;
    logic [DATA_W-1:0] alu_data;
    logic              mem_valid;
    logic              mem_ready;
    logic [ADDR_W-1:0] mem_reg;
    logic [DATA_W-1:0] mem_data;
    logic              EscReg;
    logic [ADDR_W-1:0] RegW;
    logic [DATA_W-1:0] Dado_Escrito;
    logic [31:0]       pend_mask;
    logic [CNT_W-1:0]  count;
    logic              full;
    logic              empty;
    logic [ADDR_W-1:0] byp_addr;
    logic              byp_hit;
    logic [DATA_W-1:0] byp_data;

    modport slave (
        input  alu_valid, alu_reg, alu_data,
        input  mem_valid, mem_reg, mem_data,
        input  byp_addr,
        output alu_ready, mem_ready,
        output EscReg, RegW, Dado_Escrito,
        output pend_mask, count, full, empty,
        output byp_hit, byp_data
    );

    modport master (
        output alu_valid, alu_reg, alu_data,
        output mem_valid, mem_reg, mem_data,
        output byp_addr,
        input  alu_ready, mem_ready,
        input  EscReg, RegW, Dado_Escrito,
        input  pend_mask, count, full, empty,
        input  byp_hit, byp_data
    );
endinterface

// File: rtl/wb_write_queue.sv
// Write-back queue: ALU/load results -> DEPTH-entry FIFO -> registered register-file write port.
// Latency 2 edges when empty; readiness from registered count only. Optional WB_BYPASS_EN lookup.
module wb_write_queue #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic clock,
    input  logic reset,
    wb_write_queue_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] reg_q  [DEPTH];
    logic [ADDR_W-1:0] reg_d  [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DATA_W-1:0] data_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              esc_reg_q, esc_reg_d;
    logic [ADDR_W-1:0] reg_w_q, reg_w_d;
    logic [DATA_W-1:0] dado_q, dado_d;

    logic              mem_rdy, alu_rdy;
    logic              mem_push, alu_push, pop;
    logic [PTR_W-1:0]  alu_slot;
    logic [31:0]       pend_mask_c;

    // A same-cycle pop never grants credit; the ALU yields the last slot to a pending load.
    assign mem_rdy = ~reset & (count_q < CNT_W'(DEPTH));
    assign alu_rdy = ~reset & ((count_q <= CNT_W'(DEPTH - 2)) |
                               ((count_q == CNT_W'(DEPTH - 1)) & ~bus.mem_valid));

    assign mem_push = bus.mem_valid & mem_rdy & (bus.mem_reg != '0);
    assign alu_push = bus.alu_valid & alu_rdy & (bus.alu_reg != '0);
    assign pop      = (count_q != '0);
    assign alu_slot = wr_ptr_q + PTR_W'(mem_push);

    always_comb begin
        reg_d     = reg_q;
        data_d    = data_q;
        rd_ptr_d  = rd_ptr_q;
        esc_reg_d = 1'b0;
        reg_w_d   = reg_w_q;
        dado_d    = dado_q;
        if (pop) begin
            esc_reg_d = 1'b1;
            reg_w_d   = reg_q[rd_ptr_q];
            dado_d    = data_q[rd_ptr_q];
            rd_ptr_d  = rd_ptr_q + PTR_W'(1);
        end
        if (mem_push) begin
            reg_d[wr_ptr_q]  = bus.mem_reg;
            data_d[wr_ptr_q] = bus.mem_data;
        end
        if (alu_push) begin
            reg_d[alu_slot]  = bus.alu_reg;
            data_d[alu_slot] = bus.alu_data;
        end
        wr_ptr_d = wr_ptr_q + PTR_W'(mem_push) + PTR_W'(alu_push);
        count_d  = count_q + CNT_W'(mem_push) + CNT_W'(alu_push) - CNT_W'(pop);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                reg_q[i]  <= '0;
                data_q[i] <= '0;
            end
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            esc_reg_q <= 1'b0;
            reg_w_q   <= '0;
            dado_q    <= '0;
        end else begin
            reg_q     <= reg_d;
            data_q    <= data_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            esc_reg_q <= esc_reg_d;
            reg_w_q   <= reg_w_d;
            dado_q    <= dado_d;
        end
    end

    always_comb begin
        logic [PTR_W-1:0] pm_idx;
        pm_idx      = '0;
        pend_mask_c = '0;
        if (esc_reg_q) pend_mask_c[reg_w_q] = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            pm_idx = rd_ptr_q + PTR_W'(i);
            if (CNT_W'(i) < count_q) pend_mask_c[reg_q[pm_idx]] = 1'b1;
        end
        pend_mask_c[0] = 1'b0;
    end

    assign bus.alu_ready    = alu_rdy;
    assign bus.mem_ready    = mem_rdy;
    assign bus.EscReg       = esc_reg_q;
    assign bus.RegW         = reg_w_q;
    assign bus.Dado_Escrito = dado_q;
    assign bus.pend_mask    = pend_mask_c;
    assign bus.count        = count_q;
    assign bus.full         = (count_q == CNT_W'(DEPTH));
    assign bus.empty        = (count_q == '0);

`ifdef WB_BYPASS_EN
    // Scan oldest to youngest so the youngest match overrides the output stage.
    always_comb begin
        logic [PTR_W-1:0] bp_idx;
        bp_idx       = '0;
        bus.byp_hit  = 1'b0;
        bus.byp_data = '0;
        if (bus.byp_addr != '0) begin
            if (esc_reg_q && (reg_w_q == bus.byp_addr)) begin
                bus.byp_hit  = 1'b1;
                bus.byp_data = dado_q;
            end
            for (int i = 0; i < DEPTH; i++) begin
                bp_idx = rd_ptr_q + PTR_W'(i);
                if ((CNT_W'(i) < count_q) && (reg_q[bp_idx] == bus.byp_addr)) begin
                    bus.byp_hit  = 1'b1;
                    bus.byp_data = data_q[bp_idx];
                end
            end
        end
    end
`else
    // Lookup address is deliberately ignored when the bypass is compiled out.
    logic unused_byp_addr;
    assign unused_byp_addr = ^bus.byp_addr;
    assign bus.byp_hit     = 1'b0;
    assign bus.byp_data    = '0;
`endif

endmodule

// File: tb/tb_wb_write_queue.sv
// Randomized bench for wb_write_queue: queue-based reference model plus a write-port scoreboard.
// Directed opening sequences cover latency, double accept, reg 0, near-full readiness and reset.
module tb_wb_write_queue;
    localparam int DEPTH = 4;

    typedef struct {
        logic [4:0]  r;
        logic [31:0] d;
    } ent_t;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    wb_write_queue_if #(.DEPTH(DEPTH), .DATA_W(32), .ADDR_W(5)) bus ();

    wb_write_queue #(.DEPTH(DEPTH), .DATA_W(32), .ADDR_W(5)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    ent_t mfifo[$];
    ent_t exp_q[$];
    ent_t mout;
    logic mout_vld = 1'b0;
    int   pass_cnt = 0;
    int   total_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [4:0] pick_reg();
        logic [4:0] r;
        r = 5'($urandom_range(0, 31));
        if ($urandom_range(0, 7) == 0) r = 5'd0;
        return r;
    endfunction

    task automatic check_outputs(input logic mv, input logic [4:0] ba);
        int          n;
        logic [31:0] pm;
        logic        hit;
        logic [31:0] bd;
        n  = mfifo.size();
        pm = '0;
        foreach (mfifo[i]) pm[mfifo[i].r] = 1'b1;
        if (mout_vld) pm[mout.r] = 1'b1;
        pm[0] = 1'b0;
        chk("mem_ready", 32'(bus.mem_ready), 32'(n < DEPTH));
        chk("alu_ready", 32'(bus.alu_ready),
            32'((n <= DEPTH - 2) || ((n == DEPTH - 1) && !mv)));
        chk("count", 32'(bus.count), 32'(n));
        chk("full", 32'(bus.full), 32'(n == DEPTH));
        chk("empty", 32'(bus.empty), 32'(n == 0));
        chk("esc_reg", 32'(bus.EscReg), 32'(mout_vld));
        chk("pend_mask", bus.pend_mask, pm);
        hit = 1'b0;
        bd  = '0;
`ifdef WB_BYPASS_EN
        if (ba != 5'd0) begin
            for (int i = n - 1; i >= 0; i--) begin
                if (!hit && mfifo[i].r == ba) begin
                    hit = 1'b1;
                    bd  = mfifo[i].d;
                end
            end
            if (!hit && mout_vld && mout.r == ba) begin
                hit = 1'b1;
                bd  = mout.d;
            end
        end
`endif
        chk("byp_hit", 32'(bus.byp_hit), 32'(hit));
        chk("byp_data", bus.byp_data, bd);
    endtask

    task automatic model_edge(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                              input logic mv, input logic [4:0] mr, input logic [31:0] md);
        int   n;
        logic mem_ok, alu_ok;
        ent_t e;
        n      = mfifo.size();
        mem_ok = mv && (n < DEPTH);
        alu_ok = av && ((n <= DEPTH - 2) || ((n == DEPTH - 1) && !mv));
        if (n > 0) begin
            mout     = mfifo.pop_front();
            mout_vld = 1'b1;
        end else begin
            mout_vld = 1'b0;
        end
        if (mem_ok && mr != 5'd0) begin
            e.r = mr; e.d = md;
            mfifo.push_back(e);
            exp_q.push_back(e);
        end
        if (alu_ok && ar != 5'd0) begin
            e.r = ar; e.d = ad;
            mfifo.push_back(e);
            exp_q.push_back(e);
        end
    endtask

    task automatic cycle(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                         input logic mv, input logic [4:0] mr, input logic [31:0] md,
                         input logic [4:0] ba);
        @(negedge clock);
        bus.alu_valid = av; bus.alu_reg = ar; bus.alu_data = ad;
        bus.mem_valid = mv; bus.mem_reg = mr; bus.mem_data = md;
        bus.byp_addr  = ba;
        #1;
        check_outputs(mv, ba);
        @(posedge clock);
        model_edge(av, ar, ad, mv, mr, md);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0);
    endtask

    // Scoreboard: every write seen on the port must be the next accepted write.
    initial begin
        ent_t e;
        forever begin
            @(posedge clock);
            #1;
            if (!reset && bus.EscReg) begin
                if (exp_q.size() == 0) begin
                    chk("wr_spurious", 32'(bus.EscReg), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("wr_reg", 32'(bus.RegW), 32'(e.r));
                    chk("wr_data", bus.Dado_Escrito, e.d);
                end
            end
        end
    end

    initial begin
        int pct_a, pct_m;
        reset = 1'b1;
        bus.alu_valid = 1'b0; bus.alu_reg = '0; bus.alu_data = '0;
        bus.mem_valid = 1'b0; bus.mem_reg = '0; bus.mem_data = '0;
        bus.byp_addr  = '0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        #1;
        chk("rst_alu_ready", 32'(bus.alu_ready), 32'd0);
        chk("rst_mem_ready", 32'(bus.mem_ready), 32'd0);
        chk("rst_esc_reg", 32'(bus.EscReg), 32'd0);
        chk("rst_regw", 32'(bus.RegW), 32'd0);
        chk("rst_dado", bus.Dado_Escrito, 32'd0);
        chk("rst_count", 32'(bus.count), 32'd0);
        chk("rst_empty", 32'(bus.empty), 32'd1);
        chk("rst_full", 32'(bus.full), 32'd0);
        chk("rst_pend", bus.pend_mask, 32'd0);
        @(negedge clock);
        reset = 1'b0;

        // Single ALU write, latency of two edges.
        cycle(1'b1, 5'd3, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 5'd3);
        cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd3);
        #1;
        chk("t1_esc", 32'(bus.EscReg), 32'd1);
        chk("t1_regw", 32'(bus.RegW), 32'd3);
        chk("t1_dado", bus.Dado_Escrito, 32'hDEADBEEF);
        idle(2);

        // Same-edge double accept: load first, then ALU.
        cycle(1'b1, 5'd6, 32'h22, 1'b1, 5'd5, 32'h11, 5'd0);
        #1;
        chk("t2_count", 32'(bus.count), 32'd2);
        idle(4);

        // Writes to register 0 are swallowed.
        cycle(1'b1, 5'd0, 32'hFFFF, 1'b0, 5'd0, 32'd0, 5'd0);
        #1;
        chk("t3_count", 32'(bus.count), 32'd0);
        chk("t3_pend", bus.pend_mask, 32'd0);
        idle(2);

        // Both producers streaming fill the queue to DEPTH-1.
        repeat (3) cycle(1'b1, 5'($urandom_range(1, 31)), $urandom(),
                         1'b1, 5'($urandom_range(1, 31)), $urandom(), 5'd0);
        #1;
        chk("t4_count", 32'(bus.count), 32'd3);
        cycle(1'b1, 5'd9, 32'h99, 1'b1, 5'd10, 32'hAA, 5'd10);

        // Reset with entries queued discards everything.
        @(negedge clock);
        bus.alu_valid = 1'b0; bus.mem_valid = 1'b0;
        reset = 1'b1;
        #1;
        chk("t5_esc", 32'(bus.EscReg), 32'd0);
        chk("t5_count", 32'(bus.count), 32'd0);
        chk("t5_pend", bus.pend_mask, 32'd0);
        chk("t5_alu_ready", 32'(bus.alu_ready), 32'd0);
        mfifo.delete();
        exp_q.delete();
        mout_vld = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        idle(3);

        // Two writes to the same register; lookup sees the youngest.
        cycle(1'b1, 5'd7, 32'h1, 1'b0, 5'd0, 32'd0, 5'd7);
        cycle(1'b1, 5'd7, 32'h2, 1'b0, 5'd0, 32'd0, 5'd7);
        cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd7);
        idle(2);

        // Randomized traffic at varying offered loads.
        for (int blk = 0; blk < 6; blk++) begin
            pct_a = (blk % 2 == 0) ? 90 : 30;
            pct_m = (blk % 3 == 0) ? 95 : 40;
            for (int i = 0; i < 100; i++) begin
                cycle(1'($urandom_range(0, 99) < pct_a), pick_reg(), $urandom(),
                      1'($urandom_range(0, 99) < pct_m), pick_reg(), $urandom(),
                      5'($urandom_range(0, 31)));
            end
        end

        idle(8);
        chk("drain_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
